estoque_contagem: RTL and testbench

ESTOQUE_CONTAGEM -- requirements
Module: estoque_contagem

---
 rtl/estoque_contagem.sv | 118 +++++++++++
 tb/tb_estoque_contagem.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/estoque_contagem.sv
// Cork stock counter with refill request FSM, plus bottle/dozen counter.
// Build option: define DUZIAS_BCD_EN to count Duzias as two BCD digits instead of binary.
module estoque_contagem #(
    parameter int ROLHAS_INICIAL = 20,
    parameter int ROLHAS_MAX     = 20,
    parameter int REFILL_QTD     = 15,
    parameter int LIMIAR_BAIXO   = 5
) (
    input  logic       clk,
    input  logic       Reset,
    input  logic       Dec_Rolha,
    input  logic       Inc_Duzia,
    input  logic       Ack_Reabastecer,
    output logic       Rolha_Disponivel,
    output logic [4:0] Qtd_Rolhas,
    output logic       Pedido_Reabastecer,
    output logic [3:0] Garrafas,
    output logic [7:0] Duzias,
    output logic       Duzia_Completa,
    output logic       Erro_Underflow
);

    typedef enum logic [1:0] {NORMAL, PEDIDO, RECARGA} estado_t;

    estado_t    estado_q;
    logic [4:0] qtd_q, qtd_d, qtd_base;
    logic [5:0] soma;
    logic       dec_ok, recarga;
    logic       pedido_q, erro_q, completa_q, completa_d;
    logic [3:0] garrafas_q, garrafas_d;
    logic [7:0] duzias_q, duzias_d;

    // Refill is applied on top of the (possibly) decremented stock, then saturated.
    always_comb begin
        dec_ok   = Dec_Rolha && (qtd_q != 5'd0);
        recarga  = (estado_q == PEDIDO) && Ack_Reabastecer;
        qtd_base = qtd_q - {4'd0, dec_ok};
        soma     = {1'b0, qtd_base} + 6'(REFILL_QTD);
        qtd_d    = qtd_base;
        if (recarga) begin
            qtd_d = (soma > 6'(ROLHAS_MAX)) ? 5'(ROLHAS_MAX) : soma[4:0];
        end
    end

    always_comb begin
        garrafas_d = garrafas_q;
        duzias_d   = duzias_q;
        completa_d = 1'b0;
        if (Inc_Duzia) begin
            if (garrafas_q == 4'd11) begin
                garrafas_d = 4'd0;
                completa_d = 1'b1;
`ifdef DUZIAS_BCD_EN
                if (duzias_q == 8'h99)
                    duzias_d = 8'h00;
                else if (duzias_q[3:0] == 4'd9)
                    duzias_d = {duzias_q[7:4] + 4'd1, 4'd0};
                else
                    duzias_d = duzias_q + 8'd1;
`else
                duzias_d = (duzias_q == 8'd99) ? 8'd0 : duzias_q + 8'd1;
`endif
            end else begin
                garrafas_d = garrafas_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!Reset) begin
            qtd_q      <= 5'(ROLHAS_INICIAL);
            estado_q   <= NORMAL;
            pedido_q   <= 1'b0;
            erro_q     <= 1'b0;
            garrafas_q <= 4'd0;
            duzias_q   <= 8'd0;
            completa_q <= 1'b0;
        end else begin
            qtd_q      <= qtd_d;
            garrafas_q <= garrafas_d;
            duzias_q   <= duzias_d;
            completa_q <= completa_d;
            if (Dec_Rolha && (qtd_q == 5'd0))
                erro_q <= 1'b1;
            case (estado_q)
                NORMAL: begin
                    if (qtd_d <= 5'(LIMIAR_BAIXO)) begin
                        estado_q <= PEDIDO;
                        pedido_q <= 1'b1;
                    end
                end
                PEDIDO: begin
                    if (Ack_Reabastecer) begin
                        estado_q <= RECARGA;
                        pedido_q <= 1'b0;
                    end
                end
                RECARGA: begin
                    if (!Ack_Reabastecer)
                        estado_q <= NORMAL;
                end
                default: begin
                    estado_q <= NORMAL;
                    pedido_q <= 1'b0;
                end
            endcase
        end
    end

    assign Qtd_Rolhas         = qtd_q;
    assign Rolha_Disponivel   = (qtd_q != 5'd0);
    assign Pedido_Reabastecer = pedido_q;
    assign Garrafas           = garrafas_q;
    assign Duzias             = duzias_q;
    assign Duzia_Completa     = completa_q;
    assign Erro_Underflow     = erro_q;

endmodule

// File: tb/tb_estoque_contagem.sv
// Scoreboard bench for estoque_contagem: a behavioural model queues expected outputs per cycle.
module tb_estoque_contagem;

    logic       clk = 1'b0;
    logic       Reset = 1'b1, Dec_Rolha = 1'b0, Inc_Duzia = 1'b0, Ack_Reabastecer = 1'b0;
    logic       Rolha_Disponivel, Pedido_Reabastecer, Duzia_Completa, Erro_Underflow;
    logic [4:0] Qtd_Rolhas;
    logic [3:0] Garrafas;
    logic [7:0] Duzias;

    estoque_contagem dut (
        .clk(clk), .Reset(Reset), .Dec_Rolha(Dec_Rolha), .Inc_Duzia(Inc_Duzia),
        .Ack_Reabastecer(Ack_Reabastecer), .Rolha_Disponivel(Rolha_Disponivel),
        .Qtd_Rolhas(Qtd_Rolhas), .Pedido_Reabastecer(Pedido_Reabastecer),
        .Garrafas(Garrafas), .Duzias(Duzias), .Duzia_Completa(Duzia_Completa),
        .Erro_Underflow(Erro_Underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] qtd;
        logic       disp;
        logic       ped;
        logic [3:0] gar;
        logic [7:0] duz;
        logic       comp;
        logic       err;
    } exp_t;

    exp_t sb[$];
    int checks = 0;
    int failures = 0;
    int completas = 0;

    // Reference model state (0=NORMAL, 1=PEDIDO, 2=RECARGA)
    int m_qtd = 0, m_st = 0, m_gar = 0, m_duz = 0;
    bit m_err = 0, m_comp = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [7:0] enc_duz(input int d);
`ifdef DUZIAS_BCD_EN
        return 8'(((d / 10) * 16) + (d % 10));
`else
        return 8'(d);
`endif
    endfunction

    task automatic step(input bit dec, input bit inc, input bit ack, input bit rst_n);
        exp_t e;
        int   q;
        bit   add;
        @(negedge clk);
        Dec_Rolha = dec; Inc_Duzia = inc; Ack_Reabastecer = ack; Reset = rst_n;
        if (!rst_n) begin
            m_qtd = 20; m_st = 0; m_gar = 0; m_duz = 0; m_err = 0; m_comp = 0;
        end else begin
            q   = m_qtd;
            add = (m_st == 1) && ack;
            if (dec) begin
                if (q > 0) q = q - 1;
                else m_err = 1;
            end
            if (add) q = (q + 15 > 20) ? 20 : q + 15;
            case (m_st)
                0: if (q <= 5) m_st = 1;
                1: if (ack) m_st = 2;
                default: if (!ack) m_st = 0;
            endcase
            m_qtd  = q;
            m_comp = 0;
            if (inc) begin
                if (m_gar == 11) begin
                    m_gar = 0; m_duz = (m_duz + 1) % 100; m_comp = 1;
                end else begin
                    m_gar = m_gar + 1;
                end
            end
        end
        e.qtd = 5'(m_qtd); e.disp = (m_qtd != 0); e.ped = (m_st == 1);
        e.gar = 4'(m_gar); e.duz = enc_duz(m_duz); e.comp = m_comp; e.err = m_err;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd0, 32'd1);
        end else begin
            e = sb.pop_front();
            chk("qtd", 32'(Qtd_Rolhas), 32'(e.qtd));
            chk("disp", 32'(Rolha_Disponivel), 32'(e.disp));
            chk("pedido", 32'(Pedido_Reabastecer), 32'(e.ped));
            chk("garrafas", 32'(Garrafas), 32'(e.gar));
            chk("duzias", 32'(Duzias), 32'(e.duz));
            chk("completa", 32'(Duzia_Completa), 32'(e.comp));
            chk("erro", 32'(Erro_Underflow), 32'(e.err));
        end
        if (Duzia_Completa === 1'b1) completas++;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset state
        step(0, 0, 0, 0);
        chk("rst_qtd", 32'(Qtd_Rolhas), 32'd20);
        chk("rst_disp", 32'(Rolha_Disponivel), 32'd1);
        chk("rst_ped", 32'(Pedido_Reabastecer), 32'd0);
        chk("rst_duz", 32'(Duzias), 32'd0);

        // Down to threshold, then held acknowledge gives a single saturated refill
        repeat (15) step(1, 0, 0, 1);
        chk("thr_qtd", 32'(Qtd_Rolhas), 32'd5);
        chk("thr_ped", 32'(Pedido_Reabastecer), 32'd1);
        repeat (10) step(0, 0, 1, 1);
        chk("refill_qtd", 32'(Qtd_Rolhas), 32'd20);
        chk("refill_ped", 32'(Pedido_Reabastecer), 32'd0);
        step(0, 0, 0, 1);
        repeat (3) step(0, 0, 1, 1);
        chk("ack_ignored_normal", 32'(Qtd_Rolhas), 32'd20);
        step(0, 0, 0, 1);

        // Underflow
        step(0, 0, 0, 0);
        repeat (21) step(1, 0, 0, 1);
        chk("uf_qtd", 32'(Qtd_Rolhas), 32'd0);
        chk("uf_disp", 32'(Rolha_Disponivel), 32'd0);
        chk("uf_err", 32'(Erro_Underflow), 32'd1);
        repeat (3) step(1, 0, 0, 1);
        chk("uf_sticky", 32'(Erro_Underflow), 32'd1);

        // Simultaneous decrement and refill at stock 3
        step(0, 0, 0, 0);
        repeat (17) step(1, 0, 0, 1);
        chk("s3_qtd", 32'(Qtd_Rolhas), 32'd3);
        step(1, 0, 1, 1);
        chk("s3_sum", 32'(Qtd_Rolhas), 32'd17);
        step(0, 0, 0, 1);

        // Reset while in RECARGA with ack held
        step(0, 0, 0, 0);
        repeat (15) step(1, 0, 0, 1);
        repeat (2) step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        chk("rr_qtd", 32'(Qtd_Rolhas), 32'd20);
        chk("rr_ped", 32'(Pedido_Reabastecer), 32'd0);
        repeat (3) step(0, 0, 1, 1);
        step(0, 0, 0, 1);
        chk("rr_noadd", 32'(Qtd_Rolhas), 32'd20);

        // Dozen counting, with mixed cork traffic and a multi-cycle pulse
        step(0, 0, 0, 0);
        completas = 0;
        repeat (12) step(0, 1, 0, 1);
        chk("dz_gar", 32'(Garrafas), 32'd0);
        chk("dz_duz", 32'(Duzias), 32'd1);
        step(0, 0, 0, 1);
        chk("dz_one_pulse", 32'(completas), 32'd1);
        for (int i = 0; i < 30; i++) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1);

        // Wrap of the dozen counter
        step(0, 0, 0, 0);
        repeat (1188) step(0, 1, 0, 1);
`ifdef DUZIAS_BCD_EN
        chk("dz_99", 32'(Duzias), 32'h99);
`else
        chk("dz_99", 32'(Duzias), 32'd99);
`endif
        repeat (12) step(0, 1, 0, 1);
        chk("dz_wrap", 32'(Duzias), 32'd0);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
